// File: rtl/fp16_max_reduce_if.sv
// fp16_max_reduce_if
//   Stream bundle for the FP16 max-reduction stage.
//   Input side:  iValid/oReady handshake carrying iData and iLast.
//   Output side: oValid/iReady handshake carrying oMax and oCount
//                (plus oIndex when FP16_MAXRED_ARGMAX_EN is defined).
//   Modports:
//     slave  - the reduction stage (consumes beats, produces the result)
//     master - the environment (produces beats, consumes the result)
//   Parameters: Bits (operand width), CntW (beat-counter width).
interface fp16_max_reduce_if #(
  parameter int unsigned Bits = 16,
  parameter int unsigned CntW = 8
);
  logic            iValid;
  logic            oReady;
  logic [Bits-1:0] iData;
  logic            iLast;
  logic            oValid;
  logic            iReady;
  logic [Bits-1:0] oMax;
  logic [CntW-1:0] oCount;
`ifdef FP16_MAXRED_ARGMAX_EN
  logic [CntW-1:0] oIndex;
`endif

  modport slave (
    input  iValid, iData, iLast, iReady,
    output oReady, oValid, oMax, oCount
`ifdef FP16_MAXRED_ARGMAX_EN
    , output oIndex
`endif
  );

  modport master (
    output iValid, iData, iLast, iReady,
    input  oReady, oValid, oMax, oCount
`ifdef FP16_MAXRED_ARGMAX_EN
    , input oIndex
`endif
  );
endinterface

// File: rtl/fp16_max_reduce.sv
// fp16_max_reduce
//   Streaming max-reduction stage. Accepts a frame of FP16 words, keeps a
//   registered running maximum using sign-magnitude ordering, and on the
//   frame's last beat presents the maximum and beat count until consumed.
//   Ports:
//     iClk  - clock, rising edge
//     iRst  - asynchronous active-high reset
//     bus   - fp16_max_reduce_if.slave (iValid/oReady/iData/iLast in,
//             oValid/iReady/oMax/oCount out)
//   Optional feature: define FP16_MAXRED_ARGMAX_EN to add oIndex, the
//   0-based beat position of the maximum (earliest wins on ties).
module fp16_max_reduce #(
  parameter int unsigned Bits = 16,
  parameter int unsigned CntW = 8
) (
  input  logic                  iClk,
  input  logic                  iRst,
  fp16_max_reduce_if.slave      bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t          r_state;
  logic            r_valid;
  logic [Bits-1:0] r_max;
  logic [CntW-1:0] r_cnt;
`ifdef FP16_MAXRED_ARGMAX_EN
  logic [CntW-1:0] r_idx;
`endif

  logic w_ready;
  logic w_accept;
  logic w_new_gt;

  // True when a is strictly larger than b. Opposite signs: the positive one
  // wins (so +0 beats -0). Same sign: compare magnitudes, reversed for
  // negatives. NaN/Inf are ordinary bit patterns here.
  function automatic logic larger(input logic [Bits-1:0] a,
                                  input logic [Bits-1:0] b);
    logic res;
    if (a[Bits-1] != b[Bits-1])
      res = b[Bits-1];
    else if (!a[Bits-1])
      res = (a[Bits-2:0] > b[Bits-2:0]);
    else
      res = (a[Bits-2:0] < b[Bits-2:0]);
    return res;
  endfunction

  // Ready is a pure decode of registered state; iReady never reaches it.
  assign w_ready  = (r_state != HOLD);
  assign w_accept = bus.iValid && w_ready;
  assign w_new_gt = larger(bus.iData, r_max);

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_max   <= '0;
      r_cnt   <= '0;
`ifdef FP16_MAXRED_ARGMAX_EN
      r_idx   <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_max <= bus.iData;
            r_cnt <= CntW'(1);
`ifdef FP16_MAXRED_ARGMAX_EN
            r_idx <= '0;
`endif
            if (bus.iLast) begin
              r_state <= HOLD;
              r_valid <= 1'b1;
            end else begin
              r_state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (w_accept) begin
            // Strict comparison: equal patterns keep the incumbent.
            if (w_new_gt) begin
              r_max <= bus.iData;
`ifdef FP16_MAXRED_ARGMAX_EN
              // Beats seen so far equals this beat's 0-based position.
              r_idx <= r_cnt;
`endif
            end
            r_cnt <= r_cnt + CntW'(1);
            if (bus.iLast) begin
              r_state <= HOLD;
              r_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (bus.iReady) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  // Result registers are only written outside HOLD, so they stay stable
  // while oValid is high.
  assign bus.oReady = w_ready;
  assign bus.oValid = r_valid;
  assign bus.oMax   = r_max;
  assign bus.oCount = r_cnt;
`ifdef FP16_MAXRED_ARGMAX_EN
  assign bus.oIndex = r_idx;
`endif

endmodule

// File: tb/tb_fp16_max_reduce.sv
// tb_fp16_max_reduce
//   Directed self-checking bench for fp16_max_reduce. Inputs are driven and
//   outputs sampled on the falling clock edge.
module tb_fp16_max_reduce;

  logic iClk = 1'b0;
  logic iRst = 1'b1;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  fp16_max_reduce_if #(.Bits(16), .CntW(8)) bus ();

  fp16_max_reduce #(.Bits(16), .CntW(8)) dut (
    .iClk (iClk),
    .iRst (iRst),
    .bus  (bus.slave)
  );

  always #5 iClk = ~iClk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one beat starting at a falling edge; returns on the falling edge
  // after it was accepted, with iValid dropped.
  task automatic beat(input logic [15:0] d, input logic last);
    int unsigned t;
    t = 0;
    bus.iValid = 1'b1;
    bus.iData  = d;
    bus.iLast  = last;
    while (!bus.oReady && t < 20) begin
      @(negedge iClk);
      t++;
    end
    if (t >= 20) chk("ready_timeout", 32'd0, 32'd1);
    @(negedge iClk);
    bus.iValid = 1'b0;
    bus.iLast  = 1'b0;
  endtask

  // Called on the falling edge right after the last beat was accepted.
  task automatic expect_result(input string tag, input logic [15:0] mx,
                               input logic [7:0] cnt, input logic [7:0] idx);
    chk({tag, "_valid"}, 32'(bus.oValid), 32'd1);
    chk({tag, "_max"},   32'(bus.oMax),   32'(mx));
    chk({tag, "_count"}, 32'(bus.oCount), 32'(cnt));
`ifdef FP16_MAXRED_ARGMAX_EN
    chk({tag, "_index"}, 32'(bus.oIndex), 32'(idx));
`else
    if (idx != idx) chk("unused", 32'd0, 32'd1);
`endif
    chk({tag, "_hold_ready"}, 32'(bus.oReady), 32'd0);
    bus.iReady = 1'b1;
    @(negedge iClk);
    bus.iReady = 1'b0;
    chk({tag, "_consumed"}, 32'(bus.oValid), 32'd0);
    chk({tag, "_ready"},    32'(bus.oReady), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.iValid = 1'b0;
    bus.iData  = '0;
    bus.iLast  = 1'b0;
    bus.iReady = 1'b0;

    // Reset state
    repeat (2) @(negedge iClk);
    chk("rst_valid", 32'(bus.oValid), 32'd0);
    chk("rst_max",   32'(bus.oMax),   32'd0);
    chk("rst_count", 32'(bus.oCount), 32'd0);
    iRst = 1'b0;
    @(negedge iClk);
    chk("rst_ready", 32'(bus.oReady), 32'd1);

    // 1: positive frame with a gap mid-frame
    beat(16'h3C00, 1'b0);
    @(negedge iClk);
    chk("t1_gap_valid", 32'(bus.oValid), 32'd0);
    chk("t1_gap_max",   32'(bus.oMax),   32'h3C00);
    beat(16'h4000, 1'b0);
    beat(16'h3E00, 1'b1);
    expect_result("t1", 16'h4000, 8'd3, 8'd1);

    // 2: negative frame, then zero ordering
    beat(16'hBC00, 1'b0);
    beat(16'hC000, 1'b0);
    beat(16'h8000, 1'b1);
    expect_result("t2", 16'h8000, 8'd3, 8'd2);
    beat(16'h8000, 1'b0);
    beat(16'h0000, 1'b1);
    expect_result("t2z", 16'h0000, 8'd2, 8'd1);

    // 3: single-beat frame
    beat(16'hC000, 1'b1);
    expect_result("t3", 16'hC000, 8'd1, 8'd0);

    // 4: backpressure with a pending beat that must wait for the consume
    beat(16'h3C00, 1'b0);
    beat(16'h4400, 1'b1);
    bus.iValid = 1'b1;
    bus.iData  = 16'h7800;
    bus.iLast  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t4_bp_valid", 32'(bus.oValid), 32'd1);
      chk("t4_bp_max",   32'(bus.oMax),   32'h4400);
      chk("t4_bp_count", 32'(bus.oCount), 32'd2);
      chk("t4_bp_ready", 32'(bus.oReady), 32'd0);
      @(negedge iClk);
    end
    bus.iReady = 1'b1;
    @(negedge iClk);
    bus.iReady = 1'b0;
    chk("t4_consumed", 32'(bus.oValid), 32'd0);
    chk("t4_ready",    32'(bus.oReady), 32'd1);
    @(negedge iClk);
    bus.iValid = 1'b0;
    bus.iLast  = 1'b0;
    expect_result("t4_next", 16'h7800, 8'd1, 8'd0);

    // 5: ties and special values
    beat(16'h4000, 1'b0);
    beat(16'h4000, 1'b0);
    beat(16'h7C00, 1'b0);
    beat(16'h7E00, 1'b1);
    expect_result("t5", 16'h7E00, 8'd4, 8'd3);
    beat(16'h4000, 1'b0);
    beat(16'h4000, 1'b1);
    expect_result("t5tie", 16'h4000, 8'd2, 8'd0);

    // Count wrap: 256 beats of 0x0000..0x00FF reads count 0
    for (int i = 0; i < 256; i++)
      beat(16'(i), (i == 255) ? 1'b1 : 1'b0);
    expect_result("wrap", 16'h00FF, 8'd0, 8'd255);

    // 6: reset mid-frame after 2 of 4 beats
    beat(16'h3C00, 1'b0);
    beat(16'h4000, 1'b0);
    iRst = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(bus.oValid), 32'd0);
    chk("t6_rst_max",   32'(bus.oMax),   32'd0);
    chk("t6_rst_count", 32'(bus.oCount), 32'd0);
    @(negedge iClk);
    iRst = 1'b0;
    @(negedge iClk);
    chk("t6_ready", 32'(bus.oReady), 32'd1);
    beat(16'h3C00, 1'b1);
    expect_result("t6", 16'h3C00, 8'd1, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
